// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// With LOGIC_UNIT_FLAGS_EN defined it also carries the z/p result flags.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic [2:0]       out_op;
    logic [CNT_W-1:0] res_cnt;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic             z;
    logic             p;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, c, out_op, res_cnt, z, p
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, c, out_op, res_cnt, z, p
    );
`else
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, c, out_op, res_cnt
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, c, out_op, res_cnt
    );
`endif
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise ops per beat, with a delivered-result count.
// Define LOGIC_UNIT_FLAGS_EN to add registered zero (z) and parity (p) flags beside c.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
);
    logic             s1_adv, s2_adv, xfer;
    logic [WIDTH-1:0] f_p1;

    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] a_p1_q, a_p1_d;
    logic [WIDTH-1:0] b_p1_q, b_p1_d;
    logic [2:0]       op_p1_q, op_p1_d;

    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] c_p2_q, c_p2_d;
    logic [2:0]       op_p2_q, op_p2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic             z_p2_q, z_p2_d;
    logic             p_p2_q, p_p2_d;
`endif

    function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic [2:0]       sel);
        logic [WIDTH-1:0] r;
        r = x;
        case (sel)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: r = ~(x & y);
            3'b011: r = ~(x | y);
            3'b100: r = x ^ y;
            3'b101: r = ~(x ^ y);
            3'b110: r = ~x;
            3'b111: r = x;
        endcase
        return r;
    endfunction

    // A stage may load whenever it is empty or its occupant is leaving this cycle.
    assign s2_adv = !vld_p2_q || bus.out_ready;
    assign s1_adv = !vld_p1_q || s2_adv;
    assign xfer   = vld_p2_q && bus.out_ready;
    assign f_p1   = logic_op(a_p1_q, b_p1_q, op_p1_q);

    always_comb begin
        vld_p1_d = vld_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        op_p1_d  = op_p1_q;
        vld_p2_d = vld_p2_q;
        c_p2_d   = c_p2_q;
        op_p2_d  = op_p2_q;
        cnt_d    = cnt_q + CNT_W'(xfer);
`ifdef LOGIC_UNIT_FLAGS_EN
        z_p2_d   = z_p2_q;
        p_p2_d   = p_p2_q;
`endif
        // stage 1: capture operands
        if (s1_adv) begin
            vld_p1_d = bus.in_valid;
            if (bus.in_valid) begin
                a_p1_d  = bus.a;
                b_p1_d  = bus.b;
                op_p1_d = bus.op;
            end
        end
        // stage 2: capture result; data held when no new beat arrives
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                c_p2_d  = f_p1;
                op_p2_d = op_p1_q;
`ifdef LOGIC_UNIT_FLAGS_EN
                z_p2_d  = ~|f_p1;
                p_p2_d  = ^f_p1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            a_p1_q   <= '0;
            b_p1_q   <= '0;
            op_p1_q  <= '0;
            vld_p2_q <= 1'b0;
            c_p2_q   <= '0;
            op_p2_q  <= '0;
            cnt_q    <= '0;
`ifdef LOGIC_UNIT_FLAGS_EN
            z_p2_q   <= 1'b0;
            p_p2_q   <= 1'b0;
`endif
        end else begin
            vld_p1_q <= vld_p1_d;
            a_p1_q   <= a_p1_d;
            b_p1_q   <= b_p1_d;
            op_p1_q  <= op_p1_d;
            vld_p2_q <= vld_p2_d;
            c_p2_q   <= c_p2_d;
            op_p2_q  <= op_p2_d;
            cnt_q    <= cnt_d;
`ifdef LOGIC_UNIT_FLAGS_EN
            z_p2_q   <= z_p2_d;
            p_p2_q   <= p_p2_d;
`endif
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = vld_p2_q;
    assign bus.c         = c_p2_q;
    assign bus.out_op    = op_p2_q;
    assign bus.res_cnt   = cnt_q;
`ifdef LOGIC_UNIT_FLAGS_EN
    assign bus.z         = z_p2_q;
    assign bus.p         = p_p2_q;
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: transaction-queue reference model with directed and random scenarios.
// A second instance with a 2-bit counter shares the stimulus to observe counter wrap.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(32), .CNT_W(16)) bus ();
    logic_unit_pipe_if #(.WIDTH(32), .CNT_W(2))  bus_w ();

    assign bus_w.in_valid  = bus.in_valid;
    assign bus_w.a         = bus.a;
    assign bus_w.b         = bus.b;
    assign bus_w.op        = bus.op;
    assign bus_w.out_ready = bus.out_ready;

    logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic_unit_pipe #(.WIDTH(32), .CNT_W(2))  dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

    typedef struct {
        logic [31:0] c;
        logic [2:0]  op;
        int          acc;
    } item_t;

    item_t q[$];        // beats accepted and not yet delivered, oldest first
    int    cycle   = 0;
    int    mdl_cnt = 0;
    int    n_chk   = 0;
    int    n_pass  = 0;

    // Each op as a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [3:0]  tt[8];
        logic [31:0] r;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
        for (int i = 0; i < 32; i++) r[i] = tt[op][{a[i], b[i]}];
        return r;
    endfunction

    // The oldest beat reaches the output two edges after its acceptance.
    function automatic logic exp_out_valid();
        return (q.size() > 0) && ((cycle - q[0].acc) >= 2);
    endfunction

    // Only two beats fit; they block input only while the sink stalls.
    function automatic logic exp_in_ready(input logic ordy);
        return !((q.size() >= 2) && !ordy);
    endfunction

    task automatic model_reset();
        q.delete();
        mdl_cnt = 0;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.op        = op;
        bus.out_ready = ordy;
    endtask

    task automatic clk_edge(output logic acc, output logic xfer);
        item_t it;
        acc  = bus.in_valid && exp_in_ready(bus.out_ready);
        xfer = bus.out_ready && exp_out_valid();
        it.c   = ref_op(bus.a, bus.b, bus.op);
        it.op  = bus.op;
        it.acc = cycle;
        @(posedge clk);
        if (xfer) begin
            q.delete(0);
            mdl_cnt++;
        end
        if (acc) q.push_back(it);
        cycle++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.c !== 32'h0) $display("FAIL rst_c: got %h expected 00000000", bus.c); else n_pass++;
        n_chk++; if (bus.out_op !== 3'd0) $display("FAIL rst_out_op: got %0d expected 0", bus.out_op); else n_pass++;
        n_chk++; if (bus.res_cnt !== 16'd0) $display("FAIL rst_res_cnt: got %0d expected 0", bus.res_cnt); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_nand();
        logic [31:0] na[4], nb[4], ne[4];
        logic acc, xfer;
        int k = 0;
        na = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA5A5A5A5};
        nb = '{32'h0, 32'h0,        32'hFFFFFFFF, 32'h5A5A5A5A};
        ne = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, na[i % 4], nb[i % 4], 3'b010, 1'b1);
            clk_edge(acc, xfer);
            n_chk++; if (bus.out_valid !== exp_out_valid()) $display("FAIL nand_out_valid: got %b expected %b", bus.out_valid, exp_out_valid()); else n_pass++;
            if (bus.out_valid === 1'b1 && k < 4) begin
                n_chk++; if (bus.c !== ne[k]) $display("FAIL nand_c: got %h expected %h", bus.c, ne[k]); else n_pass++;
                k++;
            end
        end
        n_chk++; if (bus.res_cnt !== 16'd4) $display("FAIL nand_res_cnt: got %0d expected 4", bus.res_cnt); else n_pass++;
    endtask

    task automatic test_all_ops();
        logic [31:0] tab[8];
        logic acc, xfer;
        int k = 0;
        tab = '{32'h000F000F, 32'h0FFF0FFF, 32'hFFF0FFF0, 32'hF000F000,
                32'h0FF00FF0, 32'hF00FF00F, 32'hF0F0F0F0, 32'h0F0F0F0F};
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 32'h0F0F0F0F, 32'h00FF00FF, 3'(i % 8), 1'b1);
            clk_edge(acc, xfer);
            n_chk++; if (bus.out_valid !== exp_out_valid()) $display("FAIL ops_out_valid: got %b expected %b", bus.out_valid, exp_out_valid()); else n_pass++;
            if (bus.out_valid === 1'b1 && k < 8) begin
                n_chk++; if (bus.c !== tab[k] || bus.out_op !== 3'(k)) $display("FAIL ops_c: got %h/%0d expected %h/%0d", bus.c, bus.out_op, tab[k], k); else n_pass++;
                k++;
            end
        end
        n_chk++; if (k !== 8) $display("FAIL ops_count: got %0d expected 8", k); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] ba[5], bb[5], c_hold;
        logic [2:0]  bo[5];
        logic acc, xfer;
        int nacc = 0, ndel = 0;
        c_hold = '0;
        for (int i = 0; i < 5; i++) begin
            ba[i] = $urandom; bb[i] = $urandom; bo[i] = 3'($urandom_range(0, 7));
        end
        for (int i = 0; i < 6; i++) begin
            drive(nacc < 5, ba[nacc % 5], bb[nacc % 5], bo[nacc % 5], 1'b0);
            clk_edge(acc, xfer);
            if (acc) nacc++;
            if (i == 1) c_hold = bus.c;
        end
        n_chk++; if (nacc !== 2) $display("FAIL bp_accepts: got %0d expected 2", nacc); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); else n_pass++;
        n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", bus.out_valid); else n_pass++;
        n_chk++; if (bus.c !== c_hold || bus.c !== ref_op(ba[0], bb[0], bo[0])) $display("FAIL bp_hold: got %h expected %h", bus.c, ref_op(ba[0], bb[0], bo[0])); else n_pass++;
        for (int i = 0; i < 20 && ndel < 5; i++) begin
            drive(nacc < 5, ba[nacc % 5], bb[nacc % 5], bo[nacc % 5], 1'b1);
            clk_edge(acc, xfer);
            if (acc) nacc++;
            if (xfer) ndel++;
            n_chk++; if (bus.out_valid !== exp_out_valid()) $display("FAIL bp_drain_valid: got %b expected %b", bus.out_valid, exp_out_valid()); else n_pass++;
            if (exp_out_valid()) begin
                n_chk++; if (bus.c !== q[0].c || bus.out_op !== q[0].op) $display("FAIL bp_order: got %h/%0d expected %h/%0d", bus.c, bus.out_op, q[0].c, q[0].op); else n_pass++;
            end
        end
        n_chk++; if (ndel !== 5 || q.size() !== 0) $display("FAIL bp_delivered: got %0d expected 5", ndel); else n_pass++;
    endtask

    task automatic test_random();
        logic acc, xfer;
        for (int i = 0; i < 400; i++) begin
            if (i < 396) drive($urandom_range(0, 3) != 0, $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            else         drive(1'b0, '0, '0, 3'd0, 1'b1);
            clk_edge(acc, xfer);
            n_chk++; if (bus.out_valid !== exp_out_valid()) $display("FAIL rnd_out_valid: got %b expected %b", bus.out_valid, exp_out_valid()); else n_pass++;
            if (exp_out_valid()) begin
                n_chk++; if (bus.c !== q[0].c || bus.out_op !== q[0].op) $display("FAIL rnd_c: got %h/%0d expected %h/%0d", bus.c, bus.out_op, q[0].c, q[0].op); else n_pass++;
`ifdef LOGIC_UNIT_FLAGS_EN
                n_chk++; if (bus.z !== (q[0].c == 32'h0) || bus.p !== ^q[0].c) $display("FAIL rnd_flags: got z%b p%b expected z%b p%b", bus.z, bus.p, (q[0].c == 32'h0), ^q[0].c); else n_pass++;
`endif
            end
            n_chk++; if (bus.in_ready !== exp_in_ready(bus.out_ready)) $display("FAIL rnd_in_ready: got %b expected %b", bus.in_ready, exp_in_ready(bus.out_ready)); else n_pass++;
            n_chk++; if (bus.res_cnt !== 16'(mdl_cnt)) $display("FAIL rnd_res_cnt: got %0d expected %0d", bus.res_cnt, 16'(mdl_cnt)); else n_pass++;
            n_chk++; if (bus_w.res_cnt !== 2'(mdl_cnt)) $display("FAIL rnd_res_cnt_w: got %0d expected %0d", bus_w.res_cnt, 2'(mdl_cnt)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic acc, xfer;
        drive(1'b1, $urandom, $urandom, 3'd4, 1'b0);
        clk_edge(acc, xfer);
        drive(1'b1, $urandom, $urandom, 3'd1, 1'b0);
        clk_edge(acc, xfer);
        drive(1'b0, '0, '0, 3'd0, 1'b0);
        clk_edge(acc, xfer);
        n_chk++; if (bus.out_valid !== 1'b1 || q.size() !== 2) $display("FAIL mid_in_flight: got %b expected 1", bus.out_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.res_cnt !== 16'd0 || bus_w.res_cnt !== 2'd0) $display("FAIL mid_res_cnt: got %0d expected 0", bus.res_cnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 3'd0, 1'b1);
            clk_edge(acc, xfer);
            n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL mid_stale: got %b expected 0", bus.out_valid); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [1:0] wseq[5];
        logic acc, xfer;
        int nb = 0, k = 0;
        wseq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 15 && k < 5; i++) begin
            drive(nb < 5, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
            clk_edge(acc, xfer);
            if (acc) nb++;
            if (xfer) begin
                n_chk++; if (bus_w.res_cnt !== wseq[k]) $display("FAIL wrap_cnt: got %0d expected %0d", bus_w.res_cnt, wseq[k]); else n_pass++;
                k++;
            end
        end
        n_chk++; if (k !== 5) $display("FAIL wrap_deliveries: got %0d expected 5", k); else n_pass++;
    endtask

`ifdef LOGIC_UNIT_FLAGS_EN
    task automatic test_flags();
        logic acc, xfer;
        logic ez[2], ep[2];
        int k = 0;
        ez = '{1'b1, 1'b0};
        ep = '{1'b0, 1'b1};
        drive(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b000, 1'b1);
        clk_edge(acc, xfer);
        drive(1'b1, 32'h00000001, $urandom, 3'b111, 1'b1);
        clk_edge(acc, xfer);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 3'd0, 1'b1);
            if (bus.out_valid === 1'b1 && k < 2) begin
                n_chk++; if (bus.z !== ez[k] || bus.p !== ep[k]) $display("FAIL flags: got z%b p%b expected z%b p%b", bus.z, bus.p, ez[k], ep[k]); else n_pass++;
                k++;
            end
            clk_edge(acc, xfer);
        end
        n_chk++; if (k !== 2) $display("FAIL flags_count: got %0d expected 2", k); else n_pass++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        test_reset();
        test_nand();
        test_all_ops();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wrap();
`ifdef LOGIC_UNIT_FLAGS_EN
        test_flags();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
